// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - opcodes, state encoding and error codes for the stack processor controller
package stack_ctrl_pkg;

    localparam logic [3:0] OP_PUSH      = 4'd0;
    localparam logic [3:0] OP_PUSH_I    = 4'd1;
    localparam logic [3:0] OP_PUSH_T    = 4'd2;
    localparam logic [3:0] OP_POP       = 4'd3;
    localparam logic [3:0] OP_ALU_FIRST = 4'd4;
    localparam logic [3:0] OP_ALU_LAST  = 4'd11;
    localparam logic [3:0] OP_JZ        = 4'd12;
    localparam logic [3:0] OP_NOT       = 4'd13;
    localparam logic [3:0] OP_JMP       = 4'd14;
    localparam logic [3:0] OP_HALT      = 4'd15;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_RD,
        ST_PUSH_MEM,
        ST_PUSH_IMM,
        ST_POP_MEM,
        ST_POP_B,
        ST_POP_A,
        ST_EXEC,
        ST_PUSH_RES,
        ST_POP_JZ,
        ST_PAUSE,
        ST_HALTED,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/stack_depth_ctr.sv
// rtl/stack_depth_ctr.sv - operand stack occupancy counter with full/empty/two-or-more flags
module stack_depth_ctr #(
    parameter int DEPTH = 16,
    localparam int SP_W = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            inc,
    input  logic            dec,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty,
    output logic            ge2
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (inc && !dec) begin
            sp <= sp + SP_W'(1);
        end else if (dec && !inc) begin
            sp <= sp - SP_W'(1);
        end
    end

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign ge2   = (sp >= SP_W'(2));

endmodule

// File: rtl/stack_ctrl_unit.sv
// rtl/stack_ctrl_unit.sv - stack processor control unit: fetch, decode, stack/RAM/ALU sequencing
module stack_ctrl_unit
    import stack_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OP_W      = 4,
    parameter int ROM_AW    = 5,
    parameter int RAM_AW    = 5,
    parameter int STK_DEPTH = 16,
    localparam int INST_W   = OP_W + DATA_W,
    localparam int SP_W     = $clog2(STK_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              step_mode,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_en,
    input  logic [INST_W-1:0] rom_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_wdata,
    input  logic [DATA_W-1:0] stk_top,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] temp_a,
    output logic [DATA_W-1:0] temp_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic [ROM_AW-1:0] pc,
    output logic [SP_W-1:0]   sp,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [1:0]        err_code
);

    state_t              state_q, state_d, end_state;
    logic [ROM_AW-1:0]   pc_q;
    logic [INST_W-1:0]   inst_q;
    logic [DATA_W-1:0]   temp_a_q, temp_b_q, res_q;
    logic [1:0]          err_q, err_d;
    logic [OP_W-1:0]     dec_op, cur_op;
    logic                dec_push_cls, dec_pop1, dec_bin;
    logic                stk_full, stk_empty, stk_ge2;

    function automatic logic op_is(input logic [OP_W-1:0] op, input logic [3:0] code);
        return op == OP_W'(code);
    endfunction

    stack_depth_ctr #(.DEPTH(STK_DEPTH)) u_depth (
        .clock (clock),
        .reset (reset),
        .inc   (stk_push),
        .dec   (stk_pop),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty),
        .ge2   (stk_ge2)
    );

    // DECODE classifies the instruction straight off the ROM bus, before inst_q is loaded
    assign dec_op       = rom_data[INST_W-1 -: OP_W];
    assign cur_op       = inst_q[INST_W-1 -: OP_W];
    assign dec_push_cls = op_is(dec_op, OP_PUSH) || op_is(dec_op, OP_PUSH_I) || op_is(dec_op, OP_PUSH_T);
    assign dec_pop1     = op_is(dec_op, OP_POP) || op_is(dec_op, OP_JZ) || op_is(dec_op, OP_NOT);
    assign dec_bin      = (dec_op >= OP_W'(OP_ALU_FIRST)) && (dec_op <= OP_W'(OP_ALU_LAST));
    assign end_state    = step_mode ? ST_PAUSE : ST_FETCH;

    always_comb begin
        state_d = state_q;
        err_d   = ERR_NONE;
        case (state_q)
            ST_IDLE, ST_PAUSE: if (start) state_d = ST_FETCH;
            ST_FETCH:          state_d = ST_DECODE;
            ST_DECODE: begin
                if (dec_push_cls && stk_full) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_OVERFLOW;
                end else if ((dec_pop1 && stk_empty) || (dec_bin && !stk_ge2)) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_UNDERFLOW;
                end else if (op_is(dec_op, OP_PUSH)) begin
                    state_d = ST_MEM_RD;
                end else if (op_is(dec_op, OP_PUSH_I) || op_is(dec_op, OP_PUSH_T)) begin
                    state_d = ST_PUSH_IMM;
                end else if (op_is(dec_op, OP_POP)) begin
                    state_d = ST_POP_MEM;
                end else if (dec_bin) begin
                    state_d = ST_POP_B;
                end else if (op_is(dec_op, OP_NOT)) begin
                    state_d = ST_POP_A;
                end else if (op_is(dec_op, OP_JZ)) begin
                    state_d = ST_POP_JZ;
                end else if (op_is(dec_op, OP_HALT)) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = end_state;
                end
            end
            ST_MEM_RD:   state_d = ST_PUSH_MEM;
            ST_POP_B:    state_d = ST_POP_A;
            ST_POP_A:    state_d = ST_EXEC;
            ST_EXEC:     state_d = ST_PUSH_RES;
            ST_PUSH_MEM, ST_PUSH_IMM, ST_POP_MEM, ST_PUSH_RES, ST_POP_JZ: state_d = end_state;
            ST_HALTED, ST_ERROR: state_d = state_q;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Strobes depend only on state_q so an asynchronous reset clears them at once
    always_comb begin
        rom_en    = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        alu_op    = '0;
        stk_wdata = res_q;
        case (state_q)
            ST_FETCH:    rom_en = 1'b1;
            ST_MEM_RD:   ram_en = 1'b1;
            ST_PUSH_MEM: begin
                stk_push  = 1'b1;
                stk_wdata = ram_rdata;
            end
            ST_PUSH_IMM: begin
                stk_push = 1'b1;
                if (op_is(cur_op, OP_PUSH_I)) stk_wdata = inst_q[DATA_W-1:0];
            end
            ST_POP_MEM: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                stk_pop = 1'b1;
            end
            ST_POP_B, ST_POP_A, ST_POP_JZ: stk_pop = 1'b1;
            ST_EXEC:     alu_op = cur_op;
            ST_PUSH_RES: stk_push = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            inst_q   <= '0;
            temp_a_q <= '0;
            temp_b_q <= '0;
            res_q    <= '0;
            err_q    <= ERR_NONE;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_DECODE: begin
                    inst_q <= rom_data;
                    if (op_is(dec_op, OP_JMP)) pc_q <= rom_data[ROM_AW-1:0];
                    else                       pc_q <= pc_q + ROM_AW'(1);
                    if (state_d == ST_ERROR) err_q <= err_d;
                end
                ST_POP_B:  temp_b_q <= stk_top;
                ST_POP_A:  temp_a_q <= stk_top;
                ST_EXEC:   res_q    <= alu_result;
                ST_POP_JZ: if (stk_top == '0) pc_q <= inst_q[ROM_AW-1:0];
                default: ;
            endcase
        end
    end

    assign rom_addr  = pc_q;
    assign ram_addr  = inst_q[RAM_AW-1:0];
    assign ram_wdata = stk_top;
    assign temp_a    = temp_a_q;
    assign temp_b    = temp_b_q;
    assign pc        = pc_q;
    assign err_code  = err_q;
    assign halted    = (state_q == ST_HALTED);
    assign error     = (state_q == ST_ERROR);
    assign busy      = !(state_q inside {ST_IDLE, ST_PAUSE, ST_HALTED, ST_ERROR});

endmodule

// File: tb/tb_stack_ctrl_unit.sv
// tb/tb_stack_ctrl_unit.sv - bench for stack_ctrl_unit with ROM/RAM/stack/ALU models and an instruction-level reference
module tb_stack_ctrl_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic [4:0]  rom_addr;
    logic        rom_en;
    logic [11:0] rom_data;
    logic [4:0]  ram_addr;
    logic        ram_en, ram_we;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        stk_push, stk_pop;
    logic [7:0]  stk_wdata, stk_top;
    logic [3:0]  alu_op;
    logic [7:0]  temp_a, temp_b, alu_result;
    logic [4:0]  pc;
    logic [4:0]  sp;
    logic        busy, halted, error;
    logic [1:0]  err_code;

    int errors = 0;
    int checks = 0;

    stack_ctrl_unit dut (
        .clock(clock), .reset(reset), .start(start), .step_mode(step_mode),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_top(stk_top),
        .alu_op(alu_op), .temp_a(temp_a), .temp_b(temp_b), .alu_result(alu_result),
        .pc(pc), .sp(sp), .busy(busy), .halted(halted), .error(error), .err_code(err_code)
    );

    always #5 clock = ~clock;

    logic [11:0] rom [32];
    logic [7:0]  ram [32];
    logic [7:0]  ram_init [32];
    logic [7:0]  stk_mem [32];
    int          stk_n;
    int          cyc;
    int          fetch_t[$];
    int          ram_en_t[$];
    int          both_cnt = 0;

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd4:  return a + b;
            4'd5:  return a - b;
            4'd6:  return a & b;
            4'd7:  return a | b;
            4'd8:  return a ^ b;
            4'd9:  return a << b[2:0];
            4'd10: return a >> b[2:0];
            4'd11: return (a < b) ? 8'd1 : 8'd0;
            4'd13: return ~a;
            default: return 8'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, temp_a, temp_b);
    assign stk_top    = (stk_n > 0) ? stk_mem[stk_n-1] : 8'd0;

    // External ROM, RAM and operand stack, plus fetch/RAM-access timestamps
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            stk_n <= 0;
            cyc   <= 0;
            ram   <= ram_init;
            fetch_t.delete();
            ram_en_t.delete();
        end else begin
            cyc <= cyc + 1;
            if (rom_en) begin
                rom_data <= rom[rom_addr];
                fetch_t.push_back(cyc);
            end
            if (ram_en) begin
                ram_en_t.push_back(cyc);
                if (ram_we) ram[ram_addr] <= ram_wdata;
                else        ram_rdata <= ram[ram_addr];
            end
            if (stk_push) begin
                stk_mem[stk_n] <= stk_wdata;
                stk_n <= stk_n + 1;
            end
            if (stk_pop) stk_n <= stk_n - 1;
            if (stk_push && stk_pop) both_cnt <= both_cnt + 1;
        end
    end

    logic [7:0] m_stk[$];
    logic [7:0] m_ram [32];
    int         m_pc;
    logic [7:0] m_res;
    bit         m_halt, m_err;
    logic [1:0] m_code;
    int         m_cyc[$];

    function automatic logic [11:0] mk(input logic [3:0] op, input logic [7:0] v);
        return {op, v};
    endfunction

    // Instruction-level interpreter: stack as a queue, one loop pass per instruction
    task automatic model_run();
        logic [3:0] op;
        logic [7:0] v, a, b;
        m_ram = ram_init;
        m_stk.delete();
        m_cyc.delete();
        m_pc = 0; m_res = 0; m_halt = 0; m_err = 0; m_code = 0;
        for (int k = 0; k < 200 && !m_halt && !m_err; k++) begin
            op = rom[m_pc][11:8];
            v  = rom[m_pc][7:0];
            m_pc = (m_pc + 1) % 32;
            if (op <= 2 && m_stk.size() == 16) begin
                m_err = 1; m_code = 2;
            end else if (((op == 3 || op == 12 || op == 13) && m_stk.size() == 0) ||
                         (op >= 4 && op <= 11 && m_stk.size() < 2)) begin
                m_err = 1; m_code = 1;
            end else begin
                case (op)
                    4'd0:  begin m_stk.push_back(m_ram[v[4:0]]); m_cyc.push_back(4); end
                    4'd1:  begin m_stk.push_back(v); m_cyc.push_back(3); end
                    4'd2:  begin m_stk.push_back(m_res); m_cyc.push_back(3); end
                    4'd3:  begin m_ram[v[4:0]] = m_stk.pop_back(); m_cyc.push_back(3); end
                    4'd12: begin a = m_stk.pop_back(); if (a == 0) m_pc = v[4:0]; m_cyc.push_back(3); end
                    4'd13: begin a = m_stk.pop_back(); m_res = alu_f(op, a, 8'd0); m_stk.push_back(m_res); m_cyc.push_back(5); end
                    4'd14: begin m_pc = v[4:0]; m_cyc.push_back(2); end
                    4'd15: m_halt = 1;
                    default: begin
                        b = m_stk.pop_back(); a = m_stk.pop_back();
                        m_res = alu_f(op, a, b); m_stk.push_back(m_res); m_cyc.push_back(6);
                    end
                endcase
            end
        end
    endtask

    task automatic load_blank();
        for (int i = 0; i < 32; i++) begin
            rom[i] = 12'hF00;
            ram_init[i] = 8'd0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        checks++; if ({busy, halted, error, rom_en, ram_en, ram_we, stk_push, stk_pop} !== 8'b0) begin errors++; $display("FAIL reset_flags got=%b want=0", {busy, halted, error, rom_en, ram_en, ram_we, stk_push, stk_pop}); end
        checks++; if (pc !== 5'd0 || sp !== 5'd0) begin errors++; $display("FAIL reset_pc_sp got pc=%0d sp=%0d want 0 0", pc, sp); end
        checks++; if (err_code !== 2'd0 || alu_op !== 4'd0) begin errors++; $display("FAIL reset_code got err=%0d alu_op=%0d want 0 0", err_code, alu_op); end
        checks++; if (temp_a !== 8'd0 || temp_b !== 8'd0) begin errors++; $display("FAIL reset_temps got a=%h b=%h want 0 0", temp_a, temp_b); end
    endtask

    task automatic test_add_program();
        bit ok;
        bit strobe = 0;
        load_blank();
        rom[0] = mk(1, 5); rom[1] = mk(1, 3); rom[2] = mk(4, 0); rom[3] = mk(3, 7); rom[4] = mk(15, 0);
        step_mode = 0;
        do_reset();
        pulse_start();
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_timeout busy=%b want 0", busy); end
        checks++; if (halted !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL add_halted got h=%b e=%b want 1 0", halted, error); end
        checks++; if (pc !== 5'd5) begin errors++; $display("FAIL add_pc got %0d want 5", pc); end
        checks++; if (sp !== 5'd0) begin errors++; $display("FAIL add_sp got %0d want 0", sp); end
        checks++; if (ram[7] !== 8'd8) begin errors++; $display("FAIL add_ram7 got %0d want 8", ram[7]); end
        checks++; if (fetch_t.size() !== 5) begin errors++; $display("FAIL add_fetches got %0d want 5", fetch_t.size()); end
        else begin
            checks++; if (fetch_t[3] - fetch_t[2] !== 6) begin errors++; $display("FAIL add_cycles got %0d want 6", fetch_t[3] - fetch_t[2]); end
        end
        repeat (4) begin
            @(negedge clock);
            if (rom_en || ram_en || stk_push || stk_pop || busy || !halted) strobe = 1;
        end
        checks++; if (strobe) begin errors++; $display("FAIL halt_sticky got activity=1 want 0"); end
    endtask

    task automatic test_push_not();
        bit ok;
        load_blank();
        ram_init[2] = 8'h0A;
        rom[0] = mk(0, 2); rom[1] = mk(13, 0); rom[2] = mk(2, 0); rom[3] = mk(15, 0);
        step_mode = 0;
        do_reset();
        pulse_start();
        wait_idle(200, ok);
        checks++; if (!ok || !halted) begin errors++; $display("FAIL pnot_halt got h=%b want 1", halted); end
        checks++; if (sp !== 5'd2 || stk_n !== 2) begin errors++; $display("FAIL pnot_sp got sp=%0d n=%0d want 2 2", sp, stk_n); end
        checks++; if (stk_mem[0] !== 8'hF5 || stk_mem[1] !== 8'hF5) begin errors++; $display("FAIL pnot_stack got %h %h want f5 f5", stk_mem[0], stk_mem[1]); end
        checks++; if (ram_en_t.size() < 1 || fetch_t.size() < 3) begin errors++; $display("FAIL pnot_log got ram=%0d fetch=%0d want >=1 >=3", ram_en_t.size(), fetch_t.size()); end
        else begin
            checks++; if (ram_en_t[0] - fetch_t[0] !== 2) begin errors++; $display("FAIL pnot_ram_en_cycle got %0d want 2", ram_en_t[0] - fetch_t[0]); end
            checks++; if (fetch_t[1] - fetch_t[0] !== 4) begin errors++; $display("FAIL pnot_push_cycles got %0d want 4", fetch_t[1] - fetch_t[0]); end
            checks++; if (fetch_t[2] - fetch_t[1] !== 5) begin errors++; $display("FAIL pnot_not_cycles got %0d want 5", fetch_t[2] - fetch_t[1]); end
        end
    endtask

    task automatic test_jz();
        bit ok;
        for (int v = 0; v < 2; v++) begin
            load_blank();
            rom[0] = mk(1, 8'(v)); rom[1] = mk(12, 6);
            step_mode = 1;
            do_reset();
            pulse_start(); wait_idle(50, ok);
            pulse_start(); wait_idle(50, ok);
            checks++; if (pc !== ((v == 0) ? 5'd6 : 5'd2) || sp !== 5'd0) begin errors++; $display("FAIL jz%0d_pc got pc=%0d sp=%0d want %0d 0", v, pc, sp, (v == 0) ? 6 : 2); end
            pulse_start(); wait_idle(50, ok);
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL jz%0d_halt got %b want 1", v, halted); end
        end
        step_mode = 0;
    endtask

    task automatic test_overflow_underflow();
        bit ok;
        load_blank();
        for (int k = 0; k < 17; k++) rom[k] = mk(1, 8'(3 * k + 1));
        do_reset();
        pulse_start(); wait_idle(300, ok);
        checks++; if (error !== 1'b1 || err_code !== 2'd2 || halted !== 1'b0) begin errors++; $display("FAIL ovf_code got e=%b code=%0d want 1 2", error, err_code); end
        checks++; if (sp !== 5'd16 || stk_n !== 16) begin errors++; $display("FAIL ovf_sp got sp=%0d n=%0d want 16 16", sp, stk_n); end
        checks++; if (stk_mem[15] !== 8'd46) begin errors++; $display("FAIL ovf_top got %0d want 46", stk_mem[15]); end
        load_blank();
        rom[0] = mk(3, 3);
        do_reset();
        pulse_start(); wait_idle(50, ok);
        checks++; if (error !== 1'b1 || err_code !== 2'd1 || sp !== 5'd0) begin errors++; $display("FAIL udf_pop got e=%b code=%0d sp=%0d want 1 1 0", error, err_code, sp); end
        rom[0] = mk(1, 1); rom[1] = mk(4, 0);
        do_reset();
        pulse_start(); wait_idle(50, ok);
        checks++; if (error !== 1'b1 || err_code !== 2'd1 || sp !== 5'd1) begin errors++; $display("FAIL udf_alu got e=%b code=%0d sp=%0d want 1 1 1", error, err_code, sp); end
    endtask

    task automatic test_step_mode();
        bit ok;
        int nf;
        load_blank();
        rom[0] = mk(1, 9); rom[1] = mk(1, 4);
        step_mode = 1;
        do_reset();
        pulse_start(); wait_idle(50, ok);
        checks++; if (!ok || halted || error || sp !== 5'd1 || pc !== 5'd1) begin errors++; $display("FAIL step_pause got busy=%b sp=%0d pc=%0d want 0 1 1", busy, sp, pc); end
        nf = fetch_t.size();
        repeat (6) @(negedge clock);
        checks++; if (fetch_t.size() !== nf || busy !== 1'b0) begin errors++; $display("FAIL step_hold got fetches=%0d busy=%b want %0d 0", fetch_t.size(), busy, nf); end
        pulse_start(); wait_idle(50, ok);
        checks++; if (sp !== 5'd2 || stk_mem[1] !== 8'd4) begin errors++; $display("FAIL step_next got sp=%0d top=%0d want 2 4", sp, stk_mem[1]); end
        step_mode = 0;
        pulse_start(); wait_idle(50, ok);
        checks++; if (halted !== 1'b1 || pc !== 5'd3) begin errors++; $display("FAIL step_halt got h=%b pc=%0d want 1 3", halted, pc); end
    endtask

    task automatic test_reset_in_exec();
        int n = 0;
        load_blank();
        rom[0] = mk(1, 5); rom[1] = mk(1, 3); rom[2] = mk(4, 0);
        step_mode = 0;
        do_reset();
        pulse_start();
        while (alu_op !== 4'd4 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++; if (alu_op !== 4'd4) begin errors++; $display("FAIL exec_reach got alu_op=%0d want 4", alu_op); end
        reset = 1'b1;
        #1;
        checks++; if ({rom_en, ram_en, ram_we, stk_push, stk_pop, busy} !== 6'b0 || alu_op !== 4'd0) begin errors++; $display("FAIL exec_reset_strobes got %b op=%0d want 0", {rom_en, ram_en, ram_we, stk_push, stk_pop, busy}, alu_op); end
        checks++; if (pc !== 5'd0 || sp !== 5'd0) begin errors++; $display("FAIL exec_reset_pc_sp got pc=%0d sp=%0d want 0 0", pc, sp); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_jmp_wrap();
        bit ok;
        load_blank();
        rom[0] = mk(14, 31); rom[31] = mk(1, 8'h77);
        step_mode = 1;
        do_reset();
        pulse_start(); wait_idle(50, ok);
        checks++; if (pc !== 5'd31 || sp !== 5'd0) begin errors++; $display("FAIL jmp_pc got pc=%0d sp=%0d want 31 0", pc, sp); end
        pulse_start(); wait_idle(50, ok);
        checks++; if (pc !== 5'd0 || sp !== 5'd1 || stk_mem[0] !== 8'h77) begin errors++; $display("FAIL jmp_wrap got pc=%0d sp=%0d top=%h want 0 1 77", pc, sp, stk_mem[0]); end
        step_mode = 0;
    endtask

    task automatic test_random();
        bit ok;
        int r, tgt;
        for (int t = 0; t < 10; t++) begin
            load_blank();
            for (int i = 0; i < 32; i++) ram_init[i] = 8'($urandom);
            for (int i = 0; i < 12; i++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0:       rom[i] = mk(0, 8'($urandom_range(0, 31)));
                    1, 2, 9: rom[i] = mk(1, 8'($urandom));
                    3:       rom[i] = mk(2, 8'($urandom));
                    4:       rom[i] = mk(3, 8'($urandom_range(0, 31)));
                    5, 6:    rom[i] = mk(4'($urandom_range(4, 11)), 8'($urandom));
                    7:       rom[i] = mk(13, 8'($urandom));
                    default: begin
                        tgt = i + 1 + $urandom_range(0, 2);
                        if (tgt > 12) tgt = 12;
                        rom[i] = mk(12, 8'(tgt));
                    end
                endcase
            end
            model_run();
            step_mode = 0;
            do_reset();
            pulse_start();
            wait_idle(2000, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_timeout busy=%b want 0", t, busy); end
            checks++; if (halted !== m_halt || error !== m_err || err_code !== m_code) begin errors++; $display("FAIL rnd%0d_status got h=%b e=%b c=%0d want %b %b %0d", t, halted, error, err_code, m_halt, m_err, m_code); end
            checks++; if (pc !== 5'(m_pc)) begin errors++; $display("FAIL rnd%0d_pc got %0d want %0d", t, pc, m_pc); end
            checks++; if (sp !== 5'(m_stk.size()) || stk_n !== m_stk.size()) begin errors++; $display("FAIL rnd%0d_sp got sp=%0d n=%0d want %0d", t, sp, stk_n, m_stk.size()); end
            for (int k = 0; k < m_stk.size() && k < stk_n; k++) begin
                checks++; if (stk_mem[k] !== m_stk[k]) begin errors++; $display("FAIL rnd%0d_stack[%0d] got %h want %h", t, k, stk_mem[k], m_stk[k]); end
            end
            for (int a = 0; a < 32; a++) begin
                checks++; if (ram[a] !== m_ram[a]) begin errors++; $display("FAIL rnd%0d_ram[%0d] got %h want %h", t, a, ram[a], m_ram[a]); end
            end
            checks++; if (fetch_t.size() !== m_cyc.size() + 1) begin errors++; $display("FAIL rnd%0d_fetches got %0d want %0d", t, fetch_t.size(), m_cyc.size() + 1); end
            else begin
                for (int k = 0; k < m_cyc.size(); k++) begin
                    checks++; if (fetch_t[k+1] - fetch_t[k] !== m_cyc[k]) begin errors++; $display("FAIL rnd%0d_cycles[%0d] got %0d want %0d", t, k, fetch_t[k+1] - fetch_t[k], m_cyc[k]); end
                end
            end
        end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL push_pop_overlap got %0d want 0", both_cnt); end
    endtask

    initial begin
        load_blank();
        test_reset();
        test_add_program();
        test_push_not();
        test_jz();
        test_overflow_underflow();
        test_step_mode();
        test_reset_in_exec();
        test_jmp_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
